fifo_stream_reader: RTL and testbench



---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_rd_skid_buf.sv | 63 ++++++
 rtl/fifo_stream_reader.sv | 88 ++++++++
 tb/tb_fifo_stream_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream engine.
//   DEFAULT_DATA_WIDTH : default word width for FIFO and stream data
//   MAX_RD_LATENCY     : largest supported FIFO read latency
//   data_t             : word type at the default width
//   buf_depth()        : skid buffer depth needed for a given read latency
//   popcount()         : number of reads in flight
package fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned MAX_RD_LATENCY     = 2;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

  // One slot per cycle of read latency, plus one for the word being presented
  // and one so a pop can be issued while the consumer is still accepting.
  function automatic int unsigned buf_depth(input int unsigned rd_latency);
    return rd_latency + 2;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_RD_LATENCY-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_RD_LATENCY; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small circular buffer that absorbs FIFO read latency.
//   clk, rst   : clock, asynchronous active-high reset
//   wr_en      : capture wr_data at the tail
//   wr_data    : word arriving from the FIFO
//   rd_en      : pop the head word (ignored when empty)
//   rd_data    : head word, combinational from registered state
//   occupancy  : number of words held (0..DEPTH)
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [OCC_W-1:0]      occupancy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [OCC_W-1:0]      occ_q;
  logic                  do_rd;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_rd     = rd_en & (occ_q != '0);
  assign rd_data   = mem_q[rd_ptr_q];
  assign occupancy = occ_q;

  // Storage is cleared on reset so the head word reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_rd) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({wr_en, do_rd})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine for a synchronous FIFO with registered read data.
// Issues pops under a credit limit, captures returning words in a skid buffer
// and presents them as a valid/ready stream with a burst-end marker.
//   clk, rst    : clock, asynchronous active-high reset
//   en          : allow new pops (in-flight reads still complete)
//   fifo_empty  : FIFO empty flag
//   fifo_rd_en  : FIFO pop request
//   fifo_data   : FIFO read data, valid RD_LATENCY cycles after fifo_rd_en
//   m_valid     : stream word available
//   m_ready     : consumer accepts word
//   m_data      : stream word
//   m_last      : final beat of a BURST_LEN-beat burst
//   occupancy   : words held in the skid buffer (0..RD_LATENCY+2)
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              fifo_empty,
  output logic                              fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]             fifo_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_WIDTH-1:0]             m_data,
  output logic                              m_last,
  // Width is $clog2(BUF_DEPTH + 1) with BUF_DEPTH = RD_LATENCY + 2.
  output logic [$clog2(RD_LATENCY+3)-1:0]   occupancy
);

  localparam int unsigned BUF_DEPTH = buf_depth(RD_LATENCY);
  localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);
  localparam int unsigned BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [RD_LATENCY-1:0] inflight_q;
  logic [BEAT_W-1:0]     beat_q;
  logic                  capture;
  logic                  xfer;
  logic                  credit_ok;
  logic [OCC_W-1:0]      occ;

  // MSB of the shift register marks the cycle in which fifo_data is valid.
  assign capture = inflight_q[RD_LATENCY-1];
  assign xfer    = m_valid & m_ready;

  // Words buffered plus words still in flight must fit in the buffer, so a
  // capture can never find it full. No dependence on m_ready.
  assign credit_ok = (32'(occ) + popcount(MAX_RD_LATENCY'(inflight_q))) < BUF_DEPTH;

  // rst gates the pop so the FIFO sees no request while reset is held.
  assign fifo_rd_en = ~rst & en & ~fifo_empty & credit_ok;

  assign m_valid   = (occ != '0);
  assign m_last    = m_valid & (beat_q == BEAT_W'(BURST_LEN - 1));
  assign occupancy = occ;

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH),
    .OCC_W      (OCC_W)
  ) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (capture),
    .wr_data   (fifo_data),
    .rd_en     (xfer),
    .rd_data   (m_data),
    .occupancy (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
      beat_q     <= '0;
    end else begin
      // Shift left, oldest request drops off the top.
      inflight_q <= RD_LATENCY'({inflight_q, fifo_rd_en});
      if (xfer) begin
        beat_q <= (beat_q == BEAT_W'(BURST_LEN - 1)) ? '0 : beat_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default build: RD_LATENCY=1, BURST_LEN=4
  logic       en = 1'b0, m_ready = 1'b0;
  logic       fifo_empty, fifo_rd_en, m_valid, m_last;
  logic [7:0] fifo_data, m_data;
  logic [1:0] occupancy;

  // Second build: RD_LATENCY=2, BURST_LEN=1
  logic       en2 = 1'b0, m_ready2 = 1'b0;
  logic       fifo_empty2, fifo_rd_en2, m_valid2, m_last2;
  logic [7:0] fifo_data2, m_data2;
  logic [2:0] occupancy2;

  fifo_stream_reader dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .occupancy(occupancy)
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .RD_LATENCY(2), .BURST_LEN(1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .fifo_empty(fifo_empty2), .fifo_rd_en(fifo_rd_en2),
    .fifo_data(fifo_data2), .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
    .m_last(m_last2), .occupancy(occupancy2)
  );

  // FIFO models: registered read data, junk (0xEE) when no read was issued.
  logic [7:0] fmem1 [256];
  logic [7:0] fw1 = 8'd0, fr1;
  logic [7:0] fmem2 [256];
  logic [7:0] fw2 = 8'd0, fr2, f2_s1;

  assign fifo_empty  = (fr1 == fw1);
  assign fifo_empty2 = (fr2 == fw2);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fr1       <= fw1;
      fifo_data <= 8'h00;
    end else if (fifo_rd_en) begin
      fifo_data <= fmem1[fr1];
      fr1       <= fr1 + 8'd1;
    end else begin
      fifo_data <= 8'hEE;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fr2        <= fw2;
      f2_s1      <= 8'h00;
      fifo_data2 <= 8'h00;
    end else begin
      if (fifo_rd_en2) begin
        f2_s1 <= fmem2[fr2];
        fr2   <= fr2 + 8'd1;
      end else begin
        f2_s1 <= 8'hEE;
      end
      fifo_data2 <= f2_s1;
    end
  end

  task automatic push1(input logic [7:0] d);
    fmem1[fw1] = d;
    fw1 = fw1 + 8'd1;
  endtask

  task automatic push2(input logic [7:0] d);
    fmem2[fw2] = d;
    fw2 = fw2 + 8'd1;
  endtask

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  logic [8:0] got_q [$];
  logic [8:0] got2_q [$];
  int         got2_cyc [$];
  int         cyc = 0, rd_seen = 0, val_seen = 0;
  int         max_occ1 = 0, max_occ2 = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic       last_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_m_data", m_data, data_prev);
        chk("hold_m_last", m_last, last_prev);
      end
      stall_prev = m_valid & ~m_ready;
      data_prev  = m_data;
      last_prev  = m_last;
      if (m_valid && m_ready) got_q.push_back({m_last, m_data});
      if (fifo_rd_en) rd_seen++;
      if (m_valid) val_seen++;
      if (int'(occupancy) > max_occ1) max_occ1 = int'(occupancy);
      if (m_valid2 && m_ready2) begin
        got2_q.push_back({m_last2, m_data2});
        got2_cyc.push_back(cyc);
      end
      if (int'(occupancy2) > max_occ2) max_occ2 = int'(occupancy2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0; m_ready = 1'b0; en2 = 1'b0; m_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete(); got2_q.delete(); got2_cyc.delete();
    rd_seen = 0; val_seen = 0; max_occ1 = 0; max_occ2 = 0;
  endtask

  function automatic logic [8:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 9'h1FF;
  endfunction

  typedef struct {
    logic       en;
    logic       rdy;
    logic       x_rd;
    logic       x_val;
    logic [7:0] x_data;
    logic       x_last;
    logic [1:0] x_occ;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // Streaming 0x11..0x18, one vector per cycle starting when en rises.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 2'd1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 2'd1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h13, 1'b0, 2'd1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h14, 1'b1, 2'd1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 2'd1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h16, 1'b0, 2'd1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h17, 1'b0, 2'd1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h18, 1'b1, 2'd1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0};

    // Reset state
    #1;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_occupancy", occupancy, 0);
    do_reset();

    // Streaming
    for (int i = 0; i < 8; i++) push1(8'h11 + 8'(i));
    for (int i = 0; i < 11; i++) begin
      en = tbl[i].en;
      m_ready = tbl[i].rdy;
      #1;
      chk($sformatf("stream[%0d].rd_en", i), fifo_rd_en, tbl[i].x_rd);
      chk($sformatf("stream[%0d].valid", i), m_valid, tbl[i].x_val);
      chk($sformatf("stream[%0d].last", i), m_last, tbl[i].x_last);
      chk($sformatf("stream[%0d].occ", i), occupancy, tbl[i].x_occ);
      if (tbl[i].x_val) chk($sformatf("stream[%0d].data", i), m_data, tbl[i].x_data);
      tick();
    end

    // Backpressure
    do_reset();
    for (int i = 0; i < 6; i++) push1(8'h41 + 8'(i));
    en = 1'b1;
    m_ready = 1'b0;
    repeat (10) tick();
    #1;
    chk("bp_occ_sat", occupancy, 3);
    chk("bp_max_occ", max_occ1, 3);
    chk("bp_rd_en_low", fifo_rd_en, 0);
    chk("bp_valid", m_valid, 1);
    chk("bp_head", m_data, 8'h41);
    m_ready = 1'b1;
    repeat (20) tick();
    chk("bp_count", got_q.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("bp_word[%0d]", i), got_at(i), {(i == 3), 8'h41 + 8'(i)});

    // Empty FIFO, then a single word
    do_reset();
    en = 1'b1;
    m_ready = 1'b1;
    repeat (20) tick();
    chk("empty_no_rd", rd_seen, 0);
    chk("empty_no_valid", val_seen, 0);
    push1(8'hA5);
    repeat (8) tick();
    chk("single_count", got_q.size(), 1);
    chk("single_word", got_at(0), {1'b0, 8'hA5});

    // en gating after the first pop
    do_reset();
    for (int i = 0; i < 4; i++) push1(8'h51 + 8'(i));
    en = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("gate_first_rd", fifo_rd_en, 1);
    tick();
    en = 1'b0;
    rd_seen = 0;
    repeat (10) tick();
    chk("gate_no_rd", rd_seen, 0);
    chk("gate_count", got_q.size(), 1);
    chk("gate_word0", got_at(0), {1'b0, 8'h51});
    en = 1'b1;
    repeat (10) tick();
    chk("gate_total", got_q.size(), 4);
    for (int i = 1; i < 4; i++)
      chk($sformatf("gate_word[%0d]", i), got_at(i), {(i == 3), 8'h51 + 8'(i)});

    // Async reset mid-burst with occupancy=2 and one read in flight
    do_reset();
    for (int i = 0; i < 6; i++) push1(8'h21 + 8'(i));
    en = 1'b1;
    m_ready = 1'b1;
    repeat (4) tick();
    m_ready = 1'b0;
    tick();
    #1;
    chk("arst_pre_occ", occupancy, 2);
    chk("arst_pre_rd_en", fifo_rd_en, 0);
    chk("arst_pre_beats", got_q.size(), 2);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_data", m_data, 0);
    chk("arst_last", m_last, 0);
    chk("arst_rd_en", fifo_rd_en, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push1(8'h30 + 8'(i));
    repeat (12) tick();
    chk("arst_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("arst_word[%0d]", i), got_at(i), {(i == 3), 8'h30 + 8'(i)});

    // RD_LATENCY=2, BURST_LEN=1 build
    do_reset();
    for (int i = 0; i < 16; i++) push2(8'(i));
    en2 = 1'b1;
    m_ready2 = 1'b1;
    repeat (30) tick();
    chk("l2_count", got2_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < got2_q.size()) begin
        chk($sformatf("l2_word[%0d]", i), got2_q[i], {1'b1, 8'(i)});
        chk($sformatf("l2_cycle[%0d]", i), got2_cyc[i] - got2_cyc[0], i);
      end
    end
    chk("l2_max_occ_le4", (max_occ2 <= 4), 1);
    chk("l2_max_occ_nonzero", (max_occ2 > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
